alu10_cmd_driver: RTL and testbench
===================================

# alu10_cmd_driver

Sequential front-end that issues operations to a 10-bit, 6-operation combinational ALU core (CTRL 1=ADD, 2=SUB, 3=AND, 4=OR, 5=SHL, 6=SHR) and collects its results. Sits between a command producer and the ALU core. Buffers commands in a FIFO, drives the core from registers, and captures result plus flags into a response register. Also maintains sticky status flags and a completed-operation counter.

## Interface
Parameters:
- DEPTH, 4, command FIFO entries; power of 2, ≥2
- CNT_W, 16, width of op_count

Ports (clock is `clk`; reset is `rst_n`, synchronous, active-low):
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept (= !full)
- cmd_a  in  10  operand A
- cmd_b  in  10  operand B
- cmd_op  in  3  ALU CTRL code
- alu_a  out  10  registered A to ALU core
- alu_b  out  10  registered B to ALU core
- alu_ctrl  out  3  registered CTRL to ALU core
- alu_y  in  10  ALU result
- alu_zero, alu_neg, alu_ovf, alu_carry  in  1 each  ALU flags
- rsp_valid  out  1  response held
- rsp_ready  in  1  consumer accepts response
- rsp_y  out  10  captured result
- rsp_flags  out  4  captured {Z,N,V,C}
- rsp_err  out  1  issued op was outside 1..6
- sticky  out  3  {ERR,OVF,CARRY}, OR-accumulated over accepted responses
- sticky_clr  in  1  clear sticky
- op_count  out  CNT_W  responses accepted (rsp_valid & rsp_ready)

## Operation
- FIFO: write on cmd_valid & cmd_ready. Pop only by FSM. Order preserved. Simultaneous push and pop is legal when not full.
- FSM states:
  - IDLE: if FIFO non-empty → pop, load alu_a/alu_b/alu_ctrl, go EXEC.
  - EXEC: capture alu_y/flags into rsp_y/rsp_flags. Set rsp_err = (alu_ctrl ∉ 1..6). Go RESP.
  - RESP: rsp_valid=1. On rsp_ready: if FIFO non-empty → pop/load and go EXEC; else go IDLE.
- rsp_y/rsp_flags/rsp_err are stable while rsp_valid=1 and rsp_ready=0.
- Invalid op (0, 7) is still issued. The core returns Y=0, so rsp_flags={1,0,0,0} and rsp_err=1. It is not dropped.
- alu_* hold their last issued values between operations.
- Sticky and counter update only on the response handshake:
  - sticky |= {rsp_err, rsp_flags[V], rsp_flags[C]}
  - op_count +1, wrapping all-ones → 0
- sticky_clr in the same cycle as a handshake: the new bits from that response survive; older bits clear.
- No arithmetic is done here. All results come from the core.

## Timing
- Reset (rst_n=0 at a rising edge) values:
  - cmd_ready=0, rsp_valid=0, rsp_y=0, rsp_flags=0, rsp_err=0
  - alu_a=0, alu_b=0, alu_ctrl=0, sticky=0, op_count=0
  - FIFO empty, FSM in IDLE
- cmd_ready=1 from the first cycle after reset is released.
- Reset mid-operation discards FIFO contents, any in-flight EXEC, and any pending response. No response is emitted for discarded commands.
- Latency with an empty pipe: command accepted at edge E0 → alu_* valid after E1 → rsp_valid=1 after E2.
- Throughput with rsp_ready tied high: one response per 2 cycles.
- Full boundary: cmd_ready is low when DEPTH entries are stored. It depends only on the stored count; a same-cycle pop does not raise it.
- Capacity under backpressure: DEPTH+1 commands are accepted (one in RESP, DEPTH in FIFO).
- Empty boundary: IDLE with an empty FIFO holds and asserts no outputs.

## Test plan
- ADD 100+23 with rsp_ready=1 → rsp_valid rises two edges after the accept edge; rsp_y=123, flags 0000, err=0; op_count=1.
- ADD 1023+2, then SUB 512−1:
  - first: rsp_y=1, C=1, V=0
  - second: rsp_y=511, V=1, C=0
  - sticky=3'b011 after both
- Backpressure, rsp_ready=0: push 6 commands (DEPTH=4) → exactly 5 accepted and cmd_ready stays 0. Release rsp_ready → 5 responses in push order, then cmd_ready returns to 1.
- Invalid CTRL=0, A=5, B=1 → rsp_y=0, rsp_flags=4'b1000, rsp_err=1, sticky[2]=1. Pulse sticky_clr → sticky=0 next cycle. sticky_clr coincident with a V=1 handshake → sticky=3'b010.
- Back-to-back SHL 11<<3 then SHR 300>>2 with rsp_ready=1 → rsp_y=88 then 75, responses two cycles apart.
- Assert rst_n=0 for one edge while in EXEC with 2 queued → all outputs return to reset values and no stale response appears afterwards. A new ADD 1+1 → rsp_y=2, op_count=1.

Source files
------------

// File: rtl/alu10_cmd_driver_if.sv
// rtl/alu10_cmd_driver_if.sv - command, ALU-core and response signals of alu10_cmd_driver
interface alu10_cmd_driver_if #(
  parameter int CNT_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [9:0]       cmd_a;
  logic [9:0]       cmd_b;
  logic [2:0]       cmd_op;
  logic [9:0]       alu_a;
  logic [9:0]       alu_b;
  logic [2:0]       alu_ctrl;
  logic [9:0]       alu_y;
  logic             alu_zero;
  logic             alu_neg;
  logic             alu_ovf;
  logic             alu_carry;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [9:0]       rsp_y;
  logic [3:0]       rsp_flags;
  logic             rsp_err;
  logic [2:0]       sticky;
  logic             sticky_clr;
  logic [CNT_W-1:0] op_count;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op,
    input  alu_y, alu_zero, alu_neg, alu_ovf, alu_carry,
    input  rsp_ready, sticky_clr,
    output cmd_ready, alu_a, alu_b, alu_ctrl,
    output rsp_valid, rsp_y, rsp_flags, rsp_err, sticky, op_count
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op,
    output alu_y, alu_zero, alu_neg, alu_ovf, alu_carry,
    output rsp_ready, sticky_clr,
    input  cmd_ready, alu_a, alu_b, alu_ctrl,
    input  rsp_valid, rsp_y, rsp_flags, rsp_err, sticky, op_count
  );
endinterface

// File: rtl/alu10_cmd_driver.sv
// rtl/alu10_cmd_driver.sv - FIFO-buffered issue/capture front-end for the 10-bit ALU core
module alu10_cmd_driver #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst_n,
  alu10_cmd_driver_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q, state_d;
  logic [22:0]      mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             ready_q, full, empty, push, pop;
  logic             capture, rsp_fire, rsp_valid;
  logic [9:0]       alu_a_q, alu_b_q, rsp_y_q;
  logic [2:0]       alu_ctrl_q, sticky_q;
  logic [3:0]       rsp_flags_q;
  logic             rsp_err_q;
  logic [CNT_W-1:0] cnt_q;

  // Readiness is held low through reset and the reset edge itself
  assign full          = (count == (AW+1)'(DEPTH));
  assign empty         = (count == '0);
  assign bus.cmd_ready = ready_q & ~full;
  assign push          = bus.cmd_valid & bus.cmd_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!empty) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = empty ? IDLE : EXEC;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pop       = 1'b0;
    capture   = 1'b0;
    rsp_fire  = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE: pop = ~empty;
      EXEC: capture = 1'b1;
      RESP: begin
        rsp_valid = 1'b1;
        rsp_fire  = bus.rsp_ready;
        pop       = bus.rsp_ready & ~empty;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.cmd_a, bus.cmd_b, bus.cmd_op};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // A clear coinciding with a handshake keeps only that response's bits
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_ctrl_q  <= '0;
      rsp_y_q     <= '0;
      rsp_flags_q <= '0;
      rsp_err_q   <= 1'b0;
      sticky_q    <= '0;
      cnt_q       <= '0;
    end else begin
      if (pop) {alu_a_q, alu_b_q, alu_ctrl_q} <= mem[rd_ptr];
      if (capture) begin
        rsp_y_q     <= bus.alu_y;
        rsp_flags_q <= {bus.alu_zero, bus.alu_neg, bus.alu_ovf, bus.alu_carry};
        rsp_err_q   <= (alu_ctrl_q == 3'd0) || (alu_ctrl_q == 3'd7);
      end
      sticky_q <= (bus.sticky_clr ? 3'b000 : sticky_q)
                | (rsp_fire ? {rsp_err_q, rsp_flags_q[1], rsp_flags_q[0]} : 3'b000);
      if (rsp_fire) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_ctrl  = alu_ctrl_q;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_y     = rsp_y_q;
  assign bus.rsp_flags = rsp_flags_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.sticky    = sticky_q;
  assign bus.op_count  = cnt_q;
endmodule

// File: tb/tb_alu10_cmd_driver.sv
// tb/tb_alu10_cmd_driver.sv - directed self-checking bench for alu10_cmd_driver
module tb_alu10_cmd_driver;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  alu10_cmd_driver_if #(.CNT_W(16)) bus ();
  alu10_cmd_driver #(.DEPTH(4), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Reference ALU core: C is carry for ADD, borrow for SUB
  logic [9:0] core_y;
  logic       core_c, core_v;
  always_comb begin
    core_y = '0;
    core_c = 1'b0;
    core_v = 1'b0;
    case (bus.alu_ctrl)
      3'd1: begin
        {core_c, core_y} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        core_v = (bus.alu_a[9] == bus.alu_b[9]) && (core_y[9] != bus.alu_a[9]);
      end
      3'd2: begin
        core_y = bus.alu_a - bus.alu_b;
        core_c = bus.alu_a < bus.alu_b;
        core_v = (bus.alu_a[9] != bus.alu_b[9]) && (core_y[9] != bus.alu_a[9]);
      end
      3'd3: core_y = bus.alu_a & bus.alu_b;
      3'd4: core_y = bus.alu_a | bus.alu_b;
      3'd5: core_y = bus.alu_a << bus.alu_b[3:0];
      3'd6: core_y = bus.alu_a >> bus.alu_b[3:0];
      default: core_y = '0;
    endcase
  end
  assign bus.alu_y     = core_y;
  assign bus.alu_zero  = (core_y == '0);
  assign bus.alu_neg   = core_y[9];
  assign bus.alu_ovf   = core_v;
  assign bus.alu_carry = core_c;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [9:0] a, input logic [9:0] b, input logic [2:0] op);
    logic rdy;
    int   n;
    bus.cmd_valid = 1'b1; bus.cmd_a = a; bus.cmd_b = b; bus.cmd_op = op;
    rdy = 1'b0;
    for (n = 0; n < 40 && !rdy; n++) begin
      rdy = bus.cmd_ready;
      tick();
    end
    bus.cmd_valid = 1'b0;
    checks++;
    if (!rdy) begin errors++; $display("FAIL send_timeout got cmd_ready=0 exp accept"); end
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (!bus.rsp_valid && n < 40) begin tick(); n++; end
    checks++;
    if (!bus.rsp_valid) begin errors++; $display("FAIL rsp_timeout got rsp_valid=0 exp 1"); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.cmd_valid = 0; bus.cmd_a = 0; bus.cmd_b = 0; bus.cmd_op = 0;
    bus.rsp_ready = 0; bus.sticky_clr = 0;
    tick(); tick();
    checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready got %0d exp 0", bus.cmd_ready); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %0d exp 0", bus.rsp_valid); end
    checks++; if ({bus.rsp_y, bus.rsp_flags, bus.rsp_err} !== 15'd0) begin errors++; $display("FAIL rst_rsp got y=%0d f=%b e=%0d exp 0", bus.rsp_y, bus.rsp_flags, bus.rsp_err); end
    checks++; if ({bus.alu_a, bus.alu_b, bus.alu_ctrl} !== 23'd0) begin errors++; $display("FAIL rst_alu got a=%0d b=%0d c=%0d exp 0", bus.alu_a, bus.alu_b, bus.alu_ctrl); end
    checks++; if (bus.sticky !== 3'b000 || bus.op_count !== 16'd0) begin errors++; $display("FAIL rst_status got sticky=%b cnt=%0d exp 0", bus.sticky, bus.op_count); end
    rst_n = 1'b1;
    tick();
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready got %0d exp 1", bus.cmd_ready); end
  endtask

  task automatic test_add_latency();
    bus.rsp_ready = 1'b1;
    bus.cmd_valid = 1'b1; bus.cmd_a = 10'd100; bus.cmd_b = 10'd23; bus.cmd_op = 3'd1;
    tick();
    bus.cmd_valid = 1'b0;
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL lat_e0_valid got %0d exp 0", bus.rsp_valid); end
    tick();
    checks++; if (bus.alu_a !== 10'd100 || bus.alu_b !== 10'd23 || bus.alu_ctrl !== 3'd1 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL lat_e1_alu got a=%0d b=%0d c=%0d v=%0d exp 100 23 1 0", bus.alu_a, bus.alu_b, bus.alu_ctrl, bus.rsp_valid); end
    tick();
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_y !== 10'd123 || bus.rsp_flags !== 4'b0000 || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL lat_e2_rsp got v=%0d y=%0d f=%b e=%0d exp 1 123 0000 0", bus.rsp_valid, bus.rsp_y, bus.rsp_flags, bus.rsp_err); end
    tick();
    checks++; if (bus.op_count !== 16'd1 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL lat_count got cnt=%0d v=%0d exp 1 0", bus.op_count, bus.rsp_valid); end
  endtask

  task automatic test_add_sub_flags();
    bus.rsp_ready = 1'b0;
    send(10'd1023, 10'd2, 3'd1);
    send(10'd512, 10'd1, 3'd2);
    wait_rsp();
    checks++; if (bus.rsp_y !== 10'd1 || bus.rsp_flags !== 4'b0001) begin errors++; $display("FAIL add_carry got y=%0d f=%b exp 1 0001", bus.rsp_y, bus.rsp_flags); end
    bus.rsp_ready = 1'b1; tick(); bus.rsp_ready = 1'b0;
    wait_rsp();
    checks++; if (bus.rsp_y !== 10'd511 || bus.rsp_flags !== 4'b0010) begin errors++; $display("FAIL sub_ovf got y=%0d f=%b exp 511 0010", bus.rsp_y, bus.rsp_flags); end
    bus.rsp_ready = 1'b1; tick(); bus.rsp_ready = 1'b0;
    checks++; if (bus.sticky !== 3'b011 || bus.op_count !== 16'd3) begin errors++; $display("FAIL sticky_vc got sticky=%b cnt=%0d exp 011 3", bus.sticky, bus.op_count); end
  endtask

  task automatic test_backpressure();
    int   acc;
    logic rdy;
    acc = 0;
    bus.rsp_ready = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      bus.cmd_valid = (acc < 6);
      bus.cmd_a = 10'(10 + acc); bus.cmd_b = 10'(acc); bus.cmd_op = 3'd1;
      rdy = bus.cmd_ready;
      tick();
      if (rdy && acc < 6) acc++;
    end
    bus.cmd_valid = 1'b0;
    checks++; if (acc !== 5 || bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_capacity got acc=%0d rdy=%0d exp 5 0", acc, bus.cmd_ready); end
    tick(); tick();
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_y !== 10'd10) begin errors++; $display("FAIL bp_hold got v=%0d y=%0d exp 1 10", bus.rsp_valid, bus.rsp_y); end
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_rsp();
      checks++; if (bus.rsp_y !== 10'(10 + 2 * k)) begin errors++; $display("FAIL bp_order%0d got y=%0d exp %0d", k, bus.rsp_y, 10 + 2 * k); end
      tick();
    end
    checks++; if (bus.cmd_ready !== 1'b1 || bus.op_count !== 16'd8 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got rdy=%0d cnt=%0d v=%0d exp 1 8 0", bus.cmd_ready, bus.op_count, bus.rsp_valid); end
  endtask

  task automatic test_invalid_sticky();
    bus.rsp_ready = 1'b1;
    send(10'd5, 10'd1, 3'd0);
    wait_rsp();
    checks++; if (bus.rsp_y !== 10'd0 || bus.rsp_flags !== 4'b1000 || bus.rsp_err !== 1'b1) begin errors++; $display("FAIL invalid_op got y=%0d f=%b e=%0d exp 0 1000 1", bus.rsp_y, bus.rsp_flags, bus.rsp_err); end
    tick();
    checks++; if (bus.sticky !== 3'b111) begin errors++; $display("FAIL sticky_err got %b exp 111", bus.sticky); end
    bus.sticky_clr = 1'b1; tick(); bus.sticky_clr = 1'b0;
    checks++; if (bus.sticky !== 3'b000) begin errors++; $display("FAIL sticky_clr got %b exp 000", bus.sticky); end
    send(10'd1023, 10'd2, 3'd1);
    wait_rsp(); tick();
    checks++; if (bus.sticky !== 3'b001) begin errors++; $display("FAIL sticky_c got %b exp 001", bus.sticky); end
    bus.rsp_ready = 1'b0;
    send(10'd512, 10'd1, 3'd2);
    wait_rsp();
    bus.sticky_clr = 1'b1; bus.rsp_ready = 1'b1;
    tick();
    bus.sticky_clr = 1'b0;
    checks++; if (bus.sticky !== 3'b010 || bus.op_count !== 16'd11) begin errors++; $display("FAIL sticky_clr_hs got sticky=%b cnt=%0d exp 010 11", bus.sticky, bus.op_count); end
  endtask

  task automatic test_back_to_back();
    bus.rsp_ready = 1'b1;
    send(10'd11, 10'd3, 3'd5);
    send(10'd300, 10'd2, 3'd6);
    wait_rsp();
    checks++; if (bus.rsp_y !== 10'd88) begin errors++; $display("FAIL shl got y=%0d exp 88", bus.rsp_y); end
    tick();
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap got v=%0d exp 0", bus.rsp_valid); end
    tick();
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_y !== 10'd75) begin errors++; $display("FAIL shr got v=%0d y=%0d exp 1 75", bus.rsp_valid, bus.rsp_y); end
    tick();
  endtask

  task automatic test_reset_midop();
    int stale;
    bus.rsp_ready = 1'b0;
    send(10'd1, 10'd2, 3'd1);
    send(10'd3, 10'd4, 3'd1);
    send(10'd5, 10'd6, 3'd1);
    bus.rsp_ready = 1'b1;
    bus.cmd_valid = 1'b1; bus.cmd_a = 10'd7; bus.cmd_b = 10'd8; bus.cmd_op = 3'd1;
    tick();
    bus.cmd_valid = 1'b0; bus.rsp_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b0 || {bus.rsp_y, bus.rsp_flags, bus.rsp_err} !== 15'd0) begin errors++; $display("FAIL midrst_rsp got v=%0d rdy=%0d y=%0d exp 0 0 0", bus.rsp_valid, bus.cmd_ready, bus.rsp_y); end
    checks++; if ({bus.alu_a, bus.alu_b, bus.alu_ctrl} !== 23'd0 || bus.sticky !== 3'b000 || bus.op_count !== 16'd0) begin errors++; $display("FAIL midrst_state got a=%0d s=%b cnt=%0d exp 0", bus.alu_a, bus.sticky, bus.op_count); end
    bus.rsp_ready = 1'b1;
    stale = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (bus.rsp_valid) stale++;
    end
    checks++; if (stale !== 0 || bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL midrst_stale got stale=%0d rdy=%0d exp 0 1", stale, bus.cmd_ready); end
    send(10'd1, 10'd1, 3'd1);
    wait_rsp();
    checks++; if (bus.rsp_y !== 10'd2) begin errors++; $display("FAIL midrst_add got y=%0d exp 2", bus.rsp_y); end
    tick();
    checks++; if (bus.op_count !== 16'd1) begin errors++; $display("FAIL midrst_count got %0d exp 1", bus.op_count); end
  endtask

  initial begin
    test_reset();
    test_add_latency();
    test_add_sub_flags();
    test_backpressure();
    test_invalid_sticky();
    test_back_to_back();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
